// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, 3-sample majority vote,
// run-time 5..8 data bits with none/even/odd parity, and a receive FIFO
// carrying per-character parity/framing flags plus a sticky overrun.
module uart_rx_cfg #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     rst,
  input  logic                     clk,
  input  logic                     Rx,
  input  logic [N-1:0]             BR,
  input  logic [1:0]               nbits,
  input  logic [1:0]               par_mode,
  input  logic                     rd,
  input  logic                     clr_ovr,
  output logic [7:0]               DATA_Rx,
  output logic                     pe,
  output logic                     fe,
  output logic                     int1,
  output logic                     eop,
  output logic                     ovr,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 10;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_n;
  logic            rx_meta, rx_s;
  logic [N-1:0]    presc, presc_n;
  logic [3:0]      tick_cnt, tick_n;
  logic            s7, s7_n, s8, s8_n;
  logic [2:0]      bit_idx, bit_n;
  logic [1:0]      nbits_l, nbits_n;
  logic [1:0]      par_l, par_n;
  logic [7:0]      data_r, data_n;
  logic            par_acc, acc_n;
  logic            pe_r, pe_n;
  logic            tick_c, decide_c, wrap_c, maj_c, push_c, fe_c, par_en_c;
  logic [2:0]      last_c;

  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]   count_n;
  logic            pop_c, full_c, push_ok_c, ovr_set_c;
  logic [EW-1:0]   char_c, head_n;

  // Two-flop synchroniser on the asynchronous pin, idling high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver next-state: oversampling timebase, bit decisions, frame assembly
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    tick_n   = tick_cnt;
    s7_n     = s7;
    s8_n     = s8;
    bit_n    = bit_idx;
    nbits_n  = nbits_l;
    par_n    = par_l;
    data_n   = data_r;
    acc_n    = par_acc;
    pe_n     = pe_r;
    push_c   = 1'b0;
    fe_c     = 1'b0;
    tick_c   = (presc == BR);
    decide_c = tick_c && (tick_cnt == 4'd9);
    wrap_c   = tick_c && (tick_cnt == 4'd15);
    maj_c    = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    par_en_c = (par_l == 2'b01) || (par_l == 2'b10);
    last_c   = 3'(nbits_l) + 3'd4;

    if (state != IDLE) begin
      presc_n = tick_c ? '0 : N'(presc + N'(1));
      if (tick_c) begin
        tick_n = tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) s7_n = rx_s;
        if (tick_cnt == 4'd8) s8_n = rx_s;
      end
    end

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          nbits_n = nbits;
          par_n   = par_mode;
          data_n  = '0;
          bit_n   = '0;
          acc_n   = 1'b0;
          pe_n    = 1'b0;
        end
      end
      START: begin
        if (decide_c && maj_c) state_n = IDLE;
        else if (wrap_c)       state_n = DATA;
      end
      DATA: begin
        if (decide_c) begin
          data_n[bit_idx] = maj_c;
          acc_n           = par_acc ^ maj_c;
        end
        if (wrap_c) begin
          if (bit_idx == last_c) state_n = par_en_c ? PARITY : STOP;
          else                   bit_n   = bit_idx + 3'd1;
        end
      end
      PARITY: begin
        if (decide_c) pe_n = (par_l == 2'b01) ? (par_acc ^ maj_c) : ~(par_acc ^ maj_c);
        if (wrap_c)   state_n = STOP;
      end
      STOP: begin
        if (decide_c) begin
          push_c  = 1'b1;
          fe_c    = ~maj_c;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state == IDLE || state_n == IDLE) begin
      presc_n = '0;
      tick_n  = '0;
    end
  end

  // FIFO next-state; a full FIFO still accepts a push when popped in the same cycle
  always_comb begin
    char_c    = {fe_c, pe_r, data_r};
    pop_c     = rd && (count != '0);
    full_c    = (count == CW'(DEPTH));
    push_ok_c = push_c && (!full_c || pop_c);
    ovr_set_c = push_c && !push_ok_c;
    wr_ptr_n  = wr_ptr + PW'(push_ok_c);
    rd_ptr_n  = rd_ptr + PW'(pop_c);
    count_n   = CW'(count + CW'(push_ok_c) - CW'(pop_c));
    if (count_n == '0)                         head_n = '0;
    else if (push_ok_c && (rd_ptr_n == wr_ptr)) head_n = char_c;
    else                                        head_n = mem[rd_ptr_n];
  end

  // Receiver and FIFO control registers, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      tick_cnt <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      bit_idx  <= '0;
      nbits_l  <= '0;
      par_l    <= '0;
      data_r   <= '0;
      par_acc  <= 1'b0;
      pe_r     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      int1     <= 1'b0;
      DATA_Rx  <= '0;
      pe       <= 1'b0;
      fe       <= 1'b0;
      eop      <= 1'b0;
      ovr      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      tick_cnt <= tick_n;
      s7       <= s7_n;
      s8       <= s8_n;
      bit_idx  <= bit_n;
      nbits_l  <= nbits_n;
      par_l    <= par_n;
      data_r   <= data_n;
      par_acc  <= acc_n;
      pe_r     <= pe_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      int1     <= (count_n != '0);
      {fe, pe, DATA_Rx} <= head_n;
      eop      <= push_c;
      busy     <= (state_n != IDLE);
      if (ovr_set_c)    ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= char_c;
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: a frame driver queues expected characters,
// a monitor pops and compares whenever the receiver presents a FIFO entry.
module tb_uart_rx_cfg;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       rst, clk, Rx, rd, clr_ovr;
  logic [N-1:0] BR;
  logic [1:0] nbits_in, par_in;
  logic [7:0] DATA_Rx;
  logic       pe, fe, int1, eop, ovr, busy;
  logic [2:0] count;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   eop_cnt = 0;
  int   cyc = 0;
  int   t_busy = 0;
  bit   busy_q = 0;
  bit   chk_lat = 0;
  bit   hold_rd = 0;

  uart_rx_cfg #(.N(N), .DEPTH(DEPTH)) dut (
    .rst(rst), .clk(clk), .Rx(Rx), .BR(BR), .nbits(nbits_in), .par_mode(par_in),
    .rd(rd), .clr_ovr(clr_ovr), .DATA_Rx(DATA_Rx), .pe(pe), .fe(fe), .int1(int1),
    .eop(eop), .ovr(ovr), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one frame at cycle resolution; optionally invert the tick-8 sample of frame bit gl_bit
  task automatic send_frame(input logic [7:0] data, input logic [1:0] nb, input logic [1:0] pm,
                            input bit bad_par, input bit bad_stop, input int gl_bit);
    int nd, nf, per, idx, cnt, gl_off;
    bit pen, pbit, pe_e, lvl;
    logic [7:0] d;
    logic [7:0] mask;
    logic [11:0] fb;
    exp_t e;
    nd   = int'(nb) + 5;
    pen  = (pm == 2'b01) || (pm == 2'b10);
    mask = 8'((1 << nd) - 1);
    d    = data & mask;
    cnt  = $countones(d);
    pbit = (pm == 2'b01) ? cnt[0] : ~cnt[0];
    if (bad_par) pbit = ~pbit;
    pe_e = pen && (((cnt + int'(pbit)) % 2) != ((pm == 2'b10) ? 1 : 0));
    e.data = d;
    e.pe   = pe_e;
    e.fe   = bad_stop;
    if (!(hold_rd && exp_q.size() >= DEPTH)) exp_q.push_back(e);
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < nd; i++) fb[1 + i] = d[i];
    idx = 1 + nd;
    if (pen) begin
      fb[idx] = pbit;
      idx++;
    end
    fb[idx] = ~bad_stop;
    nf  = idx + 1;
    per = 16 * (int'(BR) + 1);
    gl_off = (gl_bit >= 0 && gl_bit < nf) ? (16 * gl_bit + 9) * (int'(BR) + 1) : -1;
    nbits_in = nb;
    par_in   = pm;
    for (int off = 0; off < nf * per; off++) begin
      @(negedge clk);
      lvl = fb[off / per];
      if (off == gl_off) lvl = ~lvl;
      Rx = lvl;
      if (off == 2 * per) begin
        nbits_in = 2'($urandom_range(0, 3));
        par_in   = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    Rx = 1'b1;
    repeat (per + int'($urandom_range(2, 9))) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (int1 || exp_q.size() != 0); i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    check({name, "_int1"}, int'(int1), 0);
  endtask

  // Monitor: pops the DUT FIFO and compares each head entry with the scoreboard
  initial begin
    exp_t e;
    rd = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      rd = 1'b0;
      if (!rst) begin
        if (busy && !busy_q) t_busy = cyc;
        busy_q = busy;
        if (eop) begin
          eop_cnt++;
          if (chk_lat) begin
            check("eop_latency", cyc - t_busy, 154);
            chk_lat = 0;
          end
        end
        if (int1 && !hold_rd) begin
          if (exp_q.size() == 0) check("unexpected_char", int'(int1), 0);
          else begin
            e = exp_q.pop_front();
            check("data", int'(DATA_Rx), int'(e.data));
            check("pe", int'(pe), int'(e.pe));
            check("fe", int'(fe), int'(e.fe));
          end
          rd = 1'b1;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    rst = 1'b1; Rx = 1'b1; BR = '0; nbits_in = 2'b11; par_in = 2'b00; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", int'(DATA_Rx), 0);
    check("rst_pe", int'(pe), 0);
    check("rst_fe", int'(fe), 0);
    check("rst_int1", int'(int1), 0);
    check("rst_eop", int'(eop), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 0xA5 at BR=0 with latency check
    hold_rd = 1; BR = 8'd0; chk_lat = 1; e0 = eop_cnt;
    send_frame(8'hA5, 2'b11, 2'b00, 0, 0, -1);
    check("t1_int1", int'(int1), 1);
    check("t1_count", int'(count), 1);
    check("t1_eop", eop_cnt - e0, 1);
    check("t1_busy", int'(busy), 0);
    hold_rd = 0;
    drain("t1_drain");

    // 7E1 good then bad parity at BR=3
    BR = 8'd3;
    send_frame(8'h35, 2'b10, 2'b01, 0, 0, -1);
    send_frame(8'h35, 2'b10, 2'b01, 1, 0, -1);
    drain("t2_drain");

    // 5O1 framing error, then a clean frame
    BR = 8'd1;
    send_frame(8'hF6, 2'b00, 2'b10, 0, 1, -1);
    send_frame(8'h0B, 2'b00, 2'b10, 0, 0, -1);
    drain("t3_drain");

    // Short glitch is a false start
    BR = 8'd0; e0 = eop_cnt;
    @(negedge clk); Rx = 1'b0;
    repeat (4) @(negedge clk);
    Rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", int'(busy), 0);
    check("glitch_eop", eop_cnt - e0, 0);
    check("glitch_count", int'(count), 0);

    // Single inverted middle sample is outvoted
    BR = 8'd2;
    send_frame(8'h3C, 2'b11, 2'b00, 0, 0, 3);
    send_frame(8'hC3, 2'b11, 2'b01, 0, 0, 6);
    drain("t5_drain");

    // Randomised formats, errors and glitches
    for (int i = 0; i < 24; i++) begin
      BR = N'($urandom_range(0, 3));
      send_frame(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1);
    end
    drain("rand_drain");

    // Overrun: five frames into a four-deep FIFO with no reads
    hold_rd = 1; BR = 8'd0; e0 = eop_cnt;
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 2'b11, 2'b00, 0, 0, -1);
    check("ovr_count", int'(count), 4);
    check("ovr_flag", int'(ovr), 1);
    check("ovr_eops", eop_cnt - e0, 5);
    check("ovr_queued", exp_q.size(), 4);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    @(negedge clk);
    check("ovr_cleared", int'(ovr), 0);
    hold_rd = 0;
    drain("ovr_drain");
    check("ovr_final_count", int'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
